iaf_neuron: RTL and testbench
=============================

// Module: iaf_neuron
// PURPOSE
//  Single integrate-and-fire (IAF) output neuron of the spiking classifier layer.
//  - Each clock it adds the weighted sum of its binary input spikes to a membrane potential, minus a constant leak.
//  - It emits a one-cycle output spike when the potential reaches threshold.
//  - Several instances share a lateral-inhibition bus (OR of all spikes plus a global clear); any assertion clears every neuron.
// PARAMETERS
//  INPUTS     25  number of input spike lines / synapses
//  POT_WIDTH  10  membrane potential register width (unsigned)
//  THRESHOLD  32  firing threshold; fire when next potential >= THRESHOLD
//  LEAK       1   amount subtracted from the potential every non-inhibited cycle
// PORTS
//  clk         in   1       rising-edge clock
//  rstb        in   1       reset, asynchronous, active-high
//  weights_lo  in   INPUTS  bit 0 of each 2-bit synaptic weight
//  weights_hi  in   INPUTS  bit 1 of each 2-bit synaptic weight
//  signals     in   INPUTS  input spike vector, 1 = spike this cycle
//  latinhib    in   1       lateral inhibition / global clear
//  spike       out  1       output spike, registered
//  Positional order: (weights_lo, weights_hi, signals, clk, rstb, latinhib, spike).
//  One clock domain; reset is asynchronous and active-high.
// BEHAVIOUR
//  - Weight i: w[i] = {weights_hi[i], weights_lo[i]}, unsigned, range 0..3.
//  - Input sum: sum = SUM over i of (signals[i] ? w[i] : 0).
//    - Combinational, unsigned.
//    - Width clog2(3*INPUTS+1); no overflow possible.
//  - Reset: while rstb=1, potential=0 and spike=0 immediately (asynchronous).
//    - A mid-integration reset discards the accumulated charge.
//  - At each rising clk edge with rstb=0:
//    - latinhib=1: potential<=0, spike<=0. Inhibition wins over integration and firing.
//    - else:
//      - nxt = pot + sum - LEAK, computed in a wider signed/extended width.
//      - Clamp nxt to 0 if negative (leak floors at 0).
//      - Clamp nxt to 2^POT_WIDTH-1 if it overflows.
//      - If nxt >= THRESHOLD: spike<=1, potential<=0 (reset-to-zero on fire).
//      - Else: spike<=0, potential<=nxt.
//  - Latency: the spike appears on the same edge that integrates the crossing input; there is no extra pipeline stage.
//  - Spike width is exactly one cycle. It is never held, even when input continues; re-firing needs a new crossing.
//  - Self-inhibition: when the spike is ORed back into latinhib, the edge after a spike clears the potential of all neurons on the bus.
//  - Weights and signals are sampled only at clk edges. Weights are static between edges; no weight storage inside.
//  - No state beyond the potential and spike registers. No refractory counter.
// TESTING
//  1. rstb=1, random inputs/weights -> spike=0, potential=0 throughout; release rstb -> integration starts from 0.
//  2. lo=hi=all ones, signals=all ones, latinhib=spike -> sum=75, nxt=74>=32.
//     - Edge 1: spike=1.
//     - Edge 2: spike=0, potential=0.
//     - Edge 3: spike=1 again.
//  3. Only input 0 active, w[0]=2 (hi=1, lo=0) -> net +1/cycle; spike first high on edge 32, potential 0 afterwards.
//  4. latinhib held 1 with full input of case 2 -> spike stays 0, potential stays 0; drop latinhib -> spike on next edge.
//  5. w=1 on a single active input -> net 0, never fires.
//     All weights 0 -> potential stays floored at 0, no underflow.
//  6. Reach potential 20 via case 3 stimulus, assert rstb between edges -> spike/potential 0 without a clock edge.
//     Release rstb -> needs 32 further edges to fire.

Source files
------------

// File: rtl/iaf_neuron.sv
// iaf_neuron: integrate-and-fire neuron with constant leak, threshold firing and lateral inhibition
//   clk        rising-edge clock
//   rstb       asynchronous active-high reset (clears potential and spike)
//   weights_lo bit 0 of each 2-bit synaptic weight
//   weights_hi bit 1 of each 2-bit synaptic weight
//   signals    input spike vector
//   latinhib   lateral inhibition / global clear
//   spike      registered one-cycle output spike
module iaf_neuron #(
   parameter int INPUTS    = 25,
   parameter int POT_WIDTH = 10,
   parameter int THRESHOLD = 32,
   parameter int LEAK      = 1
) (
   input  logic [INPUTS-1:0] weights_lo,
   input  logic [INPUTS-1:0] weights_hi,
   input  logic [INPUTS-1:0] signals,
   input  logic              clk,
   input  logic              rstb,
   input  logic              latinhib,
   output logic              spike
);
   localparam int SW = $clog2(3*INPUTS+1);
   // two spare bits: one for carry above the potential, one for sign after the leak
   localparam int EW = (POT_WIDTH > SW ? POT_WIDTH : SW) + 2;
   localparam logic signed [EW-1:0] MAX = EW'((1 << POT_WIDTH) - 1);
   logic [POT_WIDTH-1:0] pot, nxt;
   logic [SW-1:0] sum;
   logic signed [EW-1:0] raw;
   logic fire;
   always_comb begin
      sum = '0;
      for (int i = 0; i < INPUTS; i++)
         sum = sum + (signals[i] ? SW'({weights_hi[i], weights_lo[i]}) : SW'(0));
      raw = $signed(EW'(pot)) + $signed(EW'(sum)) - $signed(EW'(LEAK));
      nxt = raw[EW-1] ? '0 : raw > MAX ? '1 : raw[POT_WIDTH-1:0];
      fire = nxt >= POT_WIDTH'(THRESHOLD);
   end
   // inhibition wins over firing; firing resets the potential to zero
   always_ff @(posedge clk or posedge rstb)
      if (rstb) begin
         pot   <= '0;
         spike <= 1'b0;
      end else begin
         spike <= !latinhib && fire;
         pot   <= (latinhib || fire) ? '0 : nxt;
      end
endmodule

// File: tb/tb_iaf_neuron.sv
// tb_iaf_neuron: directed scoreboard bench for iaf_neuron
module tb_iaf_neuron;
   logic clk = 1'b0;
   logic rstb = 1'b0;
   logic inhib_drv = 1'b0;
   logic fb = 1'b0;
   logic latinhib;
   logic [24:0] lo, hi, sig;
   logic spike;
   bit exp_q[$];
   string tag_q[$];
   int errors = 0;
   int checks = 0;
   assign latinhib = inhib_drv | (fb & spike);
   iaf_neuron dut (
      .weights_lo(lo),
      .weights_hi(hi),
      .signals(sig),
      .clk(clk),
      .rstb(rstb),
      .latinhib(latinhib),
      .spike(spike)
   );
   always #5 clk = ~clk;
   task automatic pop_check();
      bit e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (spike === e) else begin
         errors++;
         $error("FAIL %s: spike=%b expected=%b", t, spike, e);
      end
   endtask
   task automatic step(input bit e, input string t);
      exp_q.push_back(e);
      tag_q.push_back(t);
      @(posedge clk);
      #1;
      pop_check();
   endtask
   task automatic now(input bit e, input string t);
      exp_q.push_back(e);
      tag_q.push_back(t);
      pop_check();
   endtask
   task automatic set_in(input logic [24:0] l, input logic [24:0] h, input logic [24:0] s);
      lo = l;
      hi = h;
      sig = s;
   endtask
   initial begin
      set_in('0, '0, '0);
      #1 rstb = 1'b1;
      #1 now(1'b0, "rst_async");
      for (int k = 0; k < 6; k++) begin
         set_in(25'($urandom), 25'($urandom), 25'($urandom));
         step(1'b0, "rst_hold");
      end
      rstb = 1'b0;
      set_in(25'd0, 25'd1, 25'd1);
      for (int k = 1; k <= 32; k++) step(k == 32, "ramp32");
      step(1'b0, "one_cycle");
      set_in('1, '1, '1);
      fb = 1'b1;
      step(1'b1, "full_e1");
      step(1'b0, "full_e2_selfinhib");
      step(1'b1, "full_e3");
      fb = 1'b0;
      inhib_drv = 1'b1;
      for (int k = 0; k < 4; k++) step(1'b0, "inhib_hold");
      inhib_drv = 1'b0;
      step(1'b1, "inhib_drop");
      set_in(25'd1, 25'd0, 25'd1);
      for (int k = 0; k < 40; k++) step(1'b0, "net_zero");
      set_in('0, '0, '1);
      for (int k = 0; k < 10; k++) step(1'b0, "leak_floor");
      set_in(25'd0, 25'd1, 25'd1);
      for (int k = 1; k <= 32; k++) step(k == 32, "after_floor");
      set_in('1, '1, '1);
      step(1'b1, "pre_rst_fire");
      #2 rstb = 1'b1;
      #1 now(1'b0, "rst_clears_spike");
      rstb = 1'b0;
      set_in(25'd0, 25'd1, 25'd1);
      for (int k = 0; k < 20; k++) step(1'b0, "charge20");
      #2 rstb = 1'b1;
      #1 now(1'b0, "rst_mid_charge");
      rstb = 1'b0;
      for (int k = 1; k <= 32; k++) step(k == 32, "refire32");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
